mem_sync_assoc: RTL
===================

MEM_SYNC_ASSOC -- requirements
Module: mem_sync_assoc

Interface
REQ-001 CHWIDTH, 6: log2 of cache entries; CHROWS = 2**CHWIDTH.
REQ-002 ADDRWIDTH, 17: DRAM row-address width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ACT  in  1  activate request; RowId valid with it.
REQ-006 PR  in  1  precharge, closes open row.
REQ-007 RD  in  1  read to open row.
REQ-008 WR  in  1  write to open row.
REQ-009 RowId  in  ADDRWIDTH  row address, sampled on accepted ACT.
REQ-010 sync  in  1  external copy-engine done strobe.
REQ-011 flush  in  1  request write-back of all dirty entries.
REQ-012 cRowId  out  CHWIDTH  cache entry index of open row, hit or victim.
REQ-013 evictRowId  out  ADDRWIDTH  tag being written back; valid while stall in WRITE_BACK/FLUSH wait.
REQ-014 stall  out  1  high in UPDATE_TAG, WRITE_BACK, ALLOCATE, FLUSH.
REQ-015 state  out  3  current FSM state encoding.
REQ-016 flushDone  out  1  one-cycle pulse on FLUSH completion.

Function
REQ-017 Cache: CHROWS fully associative entries, each {valid, dirty, tag[ADDRWIDTH]}; round-robin victim pointer rr[CHWIDTH].
REQ-018 States: IDLE=0, ALLOCATE=1, COMPARE_TAG=2, UPDATE_TAG=3, WRITE_BACK=4, HIT_RD=5, HIT_WR=6, FLUSH=7.
REQ-019 IDLE: ACT -> COMPARE_TAG, latch RowId as openRow; else flush -> FLUSH; ACT beats flush in same cycle.
REQ-020 COMPARE_TAG, miss -> UPDATE_TAG next cycle regardless of RD/WR/PR.
REQ-021 COMPARE_TAG, hit: priority PR -> IDLE, WR -> HIT_WR, RD -> HIT_RD, else hold; cRowId = hit index.
REQ-022 HIT_WR sets dirty of the hit entry every cycle in state; HIT_RD/HIT_WR hold while command held; PR -> IDLE; command low and PR low -> COMPARE_TAG.
REQ-023 UPDATE_TAG: victim = lowest-index invalid entry, else entry rr; cRowId = victim; victim valid and dirty -> WRITE_BACK, else -> ALLOCATE; one cycle.
REQ-024 WRITE_BACK: evictRowId = victim tag; hold until sync; on sync clear victim dirty, -> ALLOCATE.
REQ-025 ALLOCATE: hold until sync; on sync write victim {valid=1, dirty=0, tag=openRow}, rr += 1 (mod CHROWS) only if victim came from rr, -> COMPARE_TAG (now a hit).
REQ-026 FLUSH: scan index 0..CHROWS-1; clean/invalid entry costs one cycle; valid dirty entry holds with evictRowId = tag until sync, then clears dirty; after index CHROWS-1 -> IDLE with flushDone pulse; valid bits unchanged.
REQ-027 sync outside WRITE_BACK/ALLOCATE/FLUSH-wait ignored; ACT outside IDLE ignored; flush outside IDLE ignored (not queued).
REQ-028 Only one entry may ever match a tag; the tag lookup is combinational on openRow.

Reset
REQ-029 rst (any state, including mid-WRITE_BACK or mid-FLUSH) -> IDLE next edge; all valid/dirty cleared, rr=0, openRow=0.
REQ-030 During/after reset: cRowId=0, evictRowId=0, stall=0, state=0, flushDone=0.

Structure
REQ-031 Package mem_sync_pkg holds the state enum typedef (3-bit, encodings above) and the entry struct typedef.
REQ-032 Sub-module tag_cam: combinational lookup giving hit, hit index, any-invalid, lowest-invalid index; table storage stays in mem_sync_assoc.

Verification (CHWIDTH=2, ADDRWIDTH=17)
REQ-033 Reset then ACT RowId=0x100 -> COMPARE_TAG, UPDATE_TAG, ALLOCATE (cRowId=0, stall=1); sync -> COMPARE_TAG hit, cRowId=0.
REQ-034 After 033, WR 2 cycles, PR -> HIT_WR then IDLE; entry 0 dirty; reopen 0x100 -> COMPARE_TAG hit with no UPDATE_TAG.
REQ-035 Fill 4 rows (0x100 dirty, rest clean); ACT 0x200 -> victim rr=0, WRITE_BACK with evictRowId=0x100; sync -> ALLOCATE; sync -> entry 0 tag 0x200, rr=1.
REQ-036 Next ACT 0x300 with clean victim entry 1 -> UPDATE_TAG directly to ALLOCATE, no WRITE_BACK.
REQ-037 Entries 1,3 dirty; flush in IDLE -> FLUSH waits at index 1 and 3 only (evictRowId = their tags), flushDone pulses once, dirty all 0, valid unchanged.
REQ-038 rst asserted while in WRITE_BACK -> IDLE, all outputs 0; subsequent ACT of previous row misses.

Source files
------------

// File: rtl/mem_sync_pkg.sv
// Shared types for the associative DRAM row cache controller: FSM state
// encoding and the per-entry {valid, dirty, tag} record.
package mem_sync_pkg;

  // Widest row address the entry record can carry.
  localparam int ROW_ADDR_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ALLOCATE    = 3'd1,
    ST_COMPARE_TAG = 3'd2,
    ST_UPDATE_TAG  = 3'd3,
    ST_WRITE_BACK  = 3'd4,
    ST_HIT_RD      = 3'd5,
    ST_HIT_WR      = 3'd6,
    ST_FLUSH       = 3'd7
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [ROW_ADDR_W-1:0] tag;
  } entry_t;

endpackage

// File: rtl/mem_sync_assoc_tag_cam.sv
// Combinational tag lookup over all cache entries: hit/hit index plus the
// lowest-index invalid entry used for victim selection.
module tag_cam
  import mem_sync_pkg::*;
#(
  parameter int CHWIDTH   = 6,
  parameter int ADDRWIDTH = 17
) (
  input  logic [(2**CHWIDTH)-1:0] i_valid,
  input  logic [ADDRWIDTH-1:0]    i_tags [2**CHWIDTH],
  input  logic [ADDRWIDTH-1:0]    i_key,
  output logic                    o_hit,
  output logic [CHWIDTH-1:0]      o_hit_idx,
  output logic                    o_any_invalid,
  output logic [CHWIDTH-1:0]      o_lowest_invalid
);

  localparam int CHROWS = 2**CHWIDTH;

  logic [CHROWS-1:0] w_match;

  genvar gi;
  generate
    for (gi = 0; gi < CHROWS; gi++) begin : g_match
      assign w_match[gi] = i_valid[gi] && (i_tags[gi] == i_key);
    end
  endgenerate

  // At most one entry can match, so OR-ing the matching indices encodes it.
  always_comb begin
    o_hit_idx = '0;
    for (int i = 0; i < CHROWS; i++) begin
      if (w_match[i]) o_hit_idx = o_hit_idx | CHWIDTH'(i);
    end
  end

  always_comb begin
    o_lowest_invalid = '0;
    for (int i = CHROWS - 1; i >= 0; i--) begin
      if (!i_valid[i]) o_lowest_invalid = CHWIDTH'(i);
    end
  end

  assign o_hit         = |w_match;
  assign o_any_invalid = ~&i_valid;

endmodule

// File: rtl/mem_sync_assoc.sv
// Fully associative DRAM open-row cache controller: tag compare, victim
// write-back / allocate handshakes with an external copy engine, and flush.
module mem_sync_assoc
  import mem_sync_pkg::*;
#(
  parameter int CHWIDTH   = 6,
  parameter int ADDRWIDTH = ROW_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ACT,
  input  logic                 PR,
  input  logic                 RD,
  input  logic                 WR,
  input  logic [ADDRWIDTH-1:0] RowId,
  input  logic                 sync,
  input  logic                 flush,
  output logic [CHWIDTH-1:0]   cRowId,
  output logic [ADDRWIDTH-1:0] evictRowId,
  output logic                 stall,
  output logic [2:0]           state,
  output logic                 flushDone
);

  localparam int CHROWS = 2**CHWIDTH;

  entry_t               r_table [CHROWS];
  state_e               r_state;
  state_e               w_state_next;
  logic [ADDRWIDTH-1:0] r_open_row;
  logic [CHWIDTH-1:0]   r_rr;
  logic [CHWIDTH-1:0]   r_victim;
  logic                 r_victim_rr;
  logic [CHWIDTH-1:0]   r_flush_idx;
  logic                 r_flush_done;

  logic [CHROWS-1:0]    w_valid_vec;
  logic [ADDRWIDTH-1:0] w_tags [CHROWS];
  logic                 w_hit;
  logic                 w_any_invalid;
  logic [CHWIDTH-1:0]   w_hit_idx;
  logic [CHWIDTH-1:0]   w_lowest_invalid;
  logic [CHWIDTH-1:0]   w_victim;
  logic                 w_flush_wait;
  logic                 w_flush_adv;
  logic                 w_flush_last;

  genvar gi;
  generate
    for (gi = 0; gi < CHROWS; gi++) begin : g_view
      assign w_valid_vec[gi] = r_table[gi].valid;
      assign w_tags[gi]      = ADDRWIDTH'(r_table[gi].tag);
    end
  endgenerate

  tag_cam #(
    .CHWIDTH   (CHWIDTH),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_tag_cam (
    .i_valid          (w_valid_vec),
    .i_tags           (w_tags),
    .i_key            (r_open_row),
    .o_hit            (w_hit),
    .o_hit_idx        (w_hit_idx),
    .o_any_invalid    (w_any_invalid),
    .o_lowest_invalid (w_lowest_invalid)
  );

  // Prefer filling a hole; only fall back to round-robin when the cache is full.
  assign w_victim     = w_any_invalid ? w_lowest_invalid : r_rr;
  assign w_flush_wait = r_table[r_flush_idx].valid && r_table[r_flush_idx].dirty;
  assign w_flush_adv  = !w_flush_wait || sync;
  assign w_flush_last = &r_flush_idx;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ACT)        w_state_next = ST_COMPARE_TAG;
        else if (flush) w_state_next = ST_FLUSH;
      end
      ST_COMPARE_TAG: begin
        if (!w_hit)  w_state_next = ST_UPDATE_TAG;
        else if (PR) w_state_next = ST_IDLE;
        else if (WR) w_state_next = ST_HIT_WR;
        else if (RD) w_state_next = ST_HIT_RD;
      end
      ST_HIT_RD: begin
        if (PR)       w_state_next = ST_IDLE;
        else if (!RD) w_state_next = ST_COMPARE_TAG;
      end
      ST_HIT_WR: begin
        if (PR)       w_state_next = ST_IDLE;
        else if (!WR) w_state_next = ST_COMPARE_TAG;
      end
      ST_UPDATE_TAG: begin
        if (r_table[w_victim].valid && r_table[w_victim].dirty) w_state_next = ST_WRITE_BACK;
        else                                                     w_state_next = ST_ALLOCATE;
      end
      ST_WRITE_BACK: if (sync) w_state_next = ST_ALLOCATE;
      ST_ALLOCATE:   if (sync) w_state_next = ST_COMPARE_TAG;
      ST_FLUSH:      if (w_flush_adv && w_flush_last) w_state_next = ST_IDLE;
      default:       w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cRowId     = '0;
    evictRowId = '0;
    stall      = 1'b0;
    state      = 3'd0;
    flushDone  = 1'b0;
    if (!rst) begin
      state     = r_state;
      flushDone = r_flush_done;
      case (r_state)
        ST_COMPARE_TAG, ST_HIT_RD, ST_HIT_WR: cRowId = w_hit ? w_hit_idx : '0;
        ST_UPDATE_TAG: begin
          cRowId = w_victim;
          stall  = 1'b1;
        end
        ST_WRITE_BACK: begin
          cRowId     = r_victim;
          evictRowId = w_tags[r_victim];
          stall      = 1'b1;
        end
        ST_ALLOCATE: begin
          cRowId = r_victim;
          stall  = 1'b1;
        end
        ST_FLUSH: begin
          cRowId = r_flush_idx;
          stall  = 1'b1;
          if (w_flush_wait) evictRowId = w_tags[r_flush_idx];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHROWS; i++) r_table[i] <= '0;
      r_open_row   <= '0;
      r_rr         <= '0;
      r_victim     <= '0;
      r_victim_rr  <= 1'b0;
      r_flush_idx  <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ACT) r_open_row <= RowId;
          r_flush_idx <= '0;
        end
        ST_HIT_WR: if (w_hit) r_table[w_hit_idx].dirty <= 1'b1;
        ST_UPDATE_TAG: begin
          r_victim    <= w_victim;
          r_victim_rr <= !w_any_invalid;
        end
        ST_WRITE_BACK: if (sync) r_table[r_victim].dirty <= 1'b0;
        ST_ALLOCATE: begin
          if (sync) begin
            r_table[r_victim] <= '{valid: 1'b1, dirty: 1'b0, tag: ROW_ADDR_W'(r_open_row)};
            if (r_victim_rr) r_rr <= r_rr + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (w_flush_adv) begin
            if (w_flush_wait) r_table[r_flush_idx].dirty <= 1'b0;
            r_flush_idx  <= r_flush_idx + 1'b1;
            r_flush_done <= w_flush_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
